// File: rtl/mem_access_unit.sv
// Memory-stage data access controller: aligns and issues loads/stores on a
// request/ready data port, extends load results, and stalls EX/MEM until done.
module mem_access_unit #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [XLEN-1:0]   addr_in,
  input  logic [XLEN-1:0]   wdata_in,
  input  logic [2:0]        funct3_in,
  input  logic              flush_in,
  input  logic              advance_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [XLEN/8-1:0] dmem_be,
  input  logic              dmem_ready,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic [XLEN-1:0]   load_data,
  output logic              load_valid,
  output logic              stall_out,
  output logic              load_misaligned,
  output logic              store_misaligned
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [NB-1:0]     r_be;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [OFFW-1:0]   r_off;
  logic              r_kill;
  logic [XLEN-1:0]   r_load_data;

  logic [1:0]        w_size;
  logic              w_illegal;
  logic              w_unaligned;
  logic              w_misaligned;
  logic              w_access;
  logic              w_start;
  logic [OFFW-1:0]   w_off;
  logic [NB-1:0]     w_mask;
  logic [NB-1:0]     w_be;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_aligned_addr;
  logic [XLEN-1:0]   w_shifted;

  // Sign/zero extension of a right-justified load value selected by funct3.
  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] d,
                                                  input logic [2:0]      f3);
    logic signed [XLEN-1:0] res;
    case (f3)
      3'b000:  res = XLEN'($signed(d[7:0]));
      3'b001:  res = XLEN'($signed(d[15:0]));
      3'b010:  res = XLEN'($signed(d[31:0]));
      3'b100:  res = XLEN'(d[7:0]);
      3'b101:  res = XLEN'(d[15:0]);
      3'b110:  res = XLEN'(d[31:0]);
      default: res = d;
    endcase
    return res;
  endfunction

  assign w_size = funct3_in[1:0];
  assign w_off  = addr_in[OFFW-1:0];

  // 64-bit-only encodings and funct3=111 are rejected as if misaligned.
  assign w_illegal = (funct3_in == 3'b111) ||
                     ((XLEN == 32) && ((w_size == 2'b11) || (funct3_in == 3'b110)));

  always_comb begin
    w_unaligned = 1'b0;
    w_mask      = '1;
    w_wdata     = wdata_in;
    case (w_size)
      2'b00: begin
        w_mask  = NB'(1);
        w_wdata = {NB{wdata_in[7:0]}};
      end
      2'b01: begin
        w_unaligned = addr_in[0];
        w_mask      = NB'(3);
        w_wdata     = {(XLEN/16){wdata_in[15:0]}};
      end
      2'b10: begin
        w_unaligned = |addr_in[1:0];
        w_mask      = NB'(15);
        w_wdata     = {(XLEN/32){wdata_in[31:0]}};
      end
      default: begin
        w_unaligned = |addr_in[2:0];
        w_mask      = '1;
        w_wdata     = wdata_in;
      end
    endcase
  end

  assign w_misaligned   = w_illegal | w_unaligned;
  assign w_access       = valid_in & (mem_read_in | mem_write_in) & ~flush_in &
                          (r_state == S_IDLE);
  assign w_start        = w_access & ~w_misaligned;
  assign w_be           = w_mask << w_off;
  assign w_aligned_addr = {addr_in[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign w_shifted      = dmem_rdata >> {r_off, 3'b000};

  assign store_misaligned = w_access & w_misaligned & mem_write_in;
  assign load_misaligned  = w_access & w_misaligned & ~mem_write_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_we        <= 1'b0;
      r_funct3    <= '0;
      r_off       <= '0;
      r_kill      <= 1'b0;
      r_load_data <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_addr   <= w_aligned_addr;
            r_wdata  <= w_wdata;
            r_be     <= w_be;
            r_we     <= mem_write_in;
            r_funct3 <= funct3_in;
            r_off    <= w_off;
            r_kill   <= 1'b0;
          end
        end
        S_BUSY: begin
          // A flushed access still has to finish its handshake on the bus.
          if (flush_in)
            r_kill <= 1'b1;
          if (dmem_ready && !r_we && !r_kill && !flush_in)
            r_load_data <= extend_load(w_shifted, r_funct3);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    dmem_req   = 1'b0;
    load_valid = 1'b0;
    stall_out  = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall_out = w_start;
        if (w_start)
          w_next = S_BUSY;
      end
      S_BUSY: begin
        dmem_req  = 1'b1;
        stall_out = 1'b1;
        if (dmem_ready)
          w_next = (r_kill || flush_in) ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        load_valid = ~r_we & ~flush_in;
        if (advance_in || flush_in)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign dmem_be    = r_be;
  assign load_data  = r_load_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected bus requests and load results
// are queued at issue time and checked by an independent monitor.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, mem_read_in, mem_write_in;
  logic [31:0] addr_in, wdata_in;
  logic [2:0]  funct3_in;
  logic        flush_in, advance_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [31:0] load_data;
  logic        load_valid, stall_out, load_misaligned, store_misaligned;

  int total = 0;
  int bad   = 0;
  logic rd_also = 1'b0;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] ld_q[$];

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .funct3_in(funct3_in), .flush_in(flush_in), .advance_in(advance_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .load_data(load_data), .load_valid(load_valid),
    .stall_out(stall_out), .load_misaligned(load_misaligned),
    .store_misaligned(store_misaligned)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Monitor: bus acceptance and consumed load results against the queues.
  always @(negedge clk) begin : monitor
    req_t        e;
    logic [31:0] ed;
    if (!reset && dmem_req && dmem_ready) begin
      if (req_q.size() == 0) begin
        total++; bad++;
        $display("FAIL req_unexpected: got addr %h expected no request", dmem_addr);
      end else begin
        e = req_q.pop_front();
        chk("req_addr", dmem_addr, e.addr);
        chk1("req_we", dmem_we, e.we);
        chk("req_be", 32'(dmem_be), 32'(e.be));
        chk("req_wdata", dmem_wdata, e.wdata);
      end
    end
    if (!reset && load_valid && advance_in) begin
      if (ld_q.size() == 0) begin
        total++; bad++;
        $display("FAIL load_unexpected: got %h expected no load", load_data);
      end else begin
        ed = ld_q.pop_front();
        chk("load_data", load_data, ed);
      end
    end
  end

  task automatic run_op(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, input logic [31:0] rdata, input int waits,
                        input int flush_cyc, input int hold, input logic done_flush,
                        input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] eld);
    logic        killed;
    logic [31:0] ealign;
    req_t        r;
    killed = (flush_cyc >= 0);
    ealign = addr & ~32'h3;
    r = {ealign, wr, ebe, ewd};
    req_q.push_back(r);
    if (!wr && !killed && !done_flush) ld_q.push_back(eld);

    @(posedge clk); #1;
    valid_in = 1'b1; mem_read_in = !wr | rd_also; mem_write_in = wr;
    addr_in = addr; wdata_in = wd; funct3_in = f3;
    advance_in = 1'b0; flush_in = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    chk1("start_stall", stall_out, 1'b1);
    chk1("start_no_req", dmem_req, 1'b0);

    for (int c = 0; c <= waits; c++) begin
      @(posedge clk); #1;
      dmem_ready = (c == waits);
      dmem_rdata = rdata;
      flush_in   = (c == flush_cyc);
      @(negedge clk);
      chk1("busy_req", dmem_req, 1'b1);
      chk1("busy_stall", stall_out, 1'b1);
      chk("busy_addr", dmem_addr, ealign);
      chk("busy_be", 32'(dmem_be), 32'(ebe));
      chk("busy_wdata", dmem_wdata, ewd);
      chk1("busy_we", dmem_we, wr);
      chk1("busy_no_lv", load_valid, 1'b0);
    end

    @(posedge clk); #1;
    dmem_ready = 1'b0; valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    advance_in = !killed && (hold == 0) && !done_flush;
    flush_in   = done_flush && !killed;
    @(negedge clk);
    if (killed) begin
      chk1("kill_idle_req", dmem_req, 1'b0);
      chk1("kill_no_lv", load_valid, 1'b0);
      chk1("kill_idle_stall", stall_out, 1'b0);
    end else begin
      chk1("done_stall", stall_out, 1'b0);
      chk1("done_no_req", dmem_req, 1'b0);
      chk1("done_lv", load_valid, !wr && !done_flush);
      if (!done_flush) begin
        for (int h = 0; h < hold; h++) begin
          @(posedge clk); #1;
          advance_in = (h == hold - 1);
          @(negedge clk);
          chk1("hold_lv", load_valid, !wr);
          chk("hold_data", load_data, eld);
        end
      end
      @(posedge clk); #1;
      advance_in = 1'b0; flush_in = 1'b0;
      @(negedge clk);
      chk1("exit_req", dmem_req, 1'b0);
      chk1("exit_lv", load_valid, 1'b0);
      chk1("exit_stall", stall_out, 1'b0);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk1({nm, "_req"}, dmem_req, 1'b0);
    chk1({nm, "_we"}, dmem_we, 1'b0);
    chk({nm, "_addr"}, dmem_addr, 32'h0);
    chk({nm, "_wdata"}, dmem_wdata, 32'h0);
    chk({nm, "_be"}, 32'(dmem_be), 32'h0);
    chk({nm, "_ldata"}, load_data, 32'h0);
    chk1({nm, "_lv"}, load_valid, 1'b0);
    chk1({nm, "_stall"}, stall_out, 1'b0);
    chk1({nm, "_lmis"}, load_misaligned, 1'b0);
    chk1({nm, "_smis"}, store_misaligned, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    addr_in = '0; wdata_in = '0; funct3_in = '0; flush_in = 1'b0;
    advance_in = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    //     wr    addr          wdata         f3      rdata         w  fl  h  df  be    wdata exp     load exp
    run_op(1'b0, 32'h0000_1000, 32'h0,        3'b010, 32'hDEADBEEF, 0, -1, 0, 0, 4'hF, 32'h0,        32'hDEADBEEF);
    run_op(1'b0, 32'h0000_1003, 32'h0,        3'b000, 32'h80112233, 0, -1, 0, 0, 4'h8, 32'h0,        32'hFFFFFF80);
    run_op(1'b0, 32'h0000_1003, 32'h0,        3'b100, 32'h80112233, 1, -1, 0, 0, 4'h8, 32'h0,        32'h00000080);
    run_op(1'b1, 32'h0000_2002, 32'h0000ABCD, 3'b001, 32'h0,        3, -1, 0, 0, 4'hC, 32'hABCDABCD, 32'h0);
    run_op(1'b0, 32'h0000_3000, 32'h0,        3'b010, 32'h12345678, 3,  1, 0, 0, 4'hF, 32'h0,        32'h0);
    run_op(1'b0, 32'h0000_1006, 32'h0,        3'b001, 32'h80010000, 0, -1, 2, 0, 4'hC, 32'h0,        32'hFFFF8001);
    run_op(1'b0, 32'h0000_1002, 32'h0,        3'b101, 32'h1234ABCD, 0, -1, 0, 0, 4'hC, 32'h0,        32'h00001234);
    run_op(1'b1, 32'h0000_1001, 32'h0000005A, 3'b000, 32'h0,        1, -1, 0, 0, 4'h2, 32'h5A5A5A5A, 32'h0);
    run_op(1'b0, 32'h0000_4000, 32'h0,        3'b010, 32'hCAFEF00D, 0, -1, 0, 1, 4'hF, 32'h0,        32'h0);
    rd_also = 1'b1;
    run_op(1'b1, 32'h0000_2004, 32'h11223344, 3'b010, 32'h0,        0, -1, 0, 0, 4'hF, 32'h11223344, 32'h0);
    rd_also = 1'b0;

    // Misaligned, illegal and flushed requests never reach the bus.
    @(posedge clk); #1;
    valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0;
    addr_in = 32'h0000_1002; funct3_in = 3'b010;
    @(negedge clk);
    chk1("mis_lw_flag", load_misaligned, 1'b1);
    chk1("mis_lw_sflag", store_misaligned, 1'b0);
    chk1("mis_lw_stall", stall_out, 1'b0);
    chk1("mis_lw_req", dmem_req, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("mis_lw_req_next", dmem_req, 1'b0);
    mem_read_in = 1'b0; mem_write_in = 1'b1; addr_in = 32'h0000_2001; wdata_in = 32'h1;
    #1;
    chk1("mis_sw_flag", store_misaligned, 1'b1);
    chk1("mis_sw_lflag", load_misaligned, 1'b0);
    chk1("mis_sw_stall", stall_out, 1'b0);
    mem_read_in = 1'b1; mem_write_in = 1'b0; addr_in = 32'h0000_1000; funct3_in = 3'b111;
    #1;
    chk1("illegal_f3_flag", load_misaligned, 1'b1);
    funct3_in = 3'b011;
    #1;
    chk1("ld_on_rv32_flag", load_misaligned, 1'b1);
    addr_in = 32'h0000_1002; funct3_in = 3'b010; flush_in = 1'b1;
    #1;
    chk1("mis_flush_mask", load_misaligned, 1'b0);
    @(posedge clk); #1;
    valid_in = 1'b0; mem_read_in = 1'b0; flush_in = 1'b0;
    @(negedge clk);
    chk1("mis_never_req", dmem_req, 1'b0);

    // Reset while the request is outstanding.
    @(posedge clk); #1;
    valid_in = 1'b1; mem_read_in = 1'b1; addr_in = 32'h0000_5000; funct3_in = 3'b010;
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk1("pre_reset_req", dmem_req, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0; valid_in = 1'b0; mem_read_in = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_reset");

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("req_q_drained", 32'(req_q.size()), 32'd0);
    chk("ld_q_drained", 32'(ld_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
